ibex_pmp_csr: RTL and testbench

- Upstream CSR register stage for the PMP checker. Holds the pmpcfg and pmpaddr machine-mode CSRs and services single-cycle CSR read/write requests from the CSR unit.
- Applies the WARL (write-any, read-legal) rules, lock rules and granularity rules to every access.
- Drives the packed per-region cfg and address buses that the PMP checker consumes.

---
 rtl/ibex_pmp_csr_if.sv | 20 ++
 rtl/ibex_pmp_csr.sv | 150 +++++++++++++++
 tb/tb_ibex_pmp_csr.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ibex_pmp_csr_if.sv
// CSR request/response channel between the CSR unit (master) and the PMP CSR stage (slave).
interface ibex_pmp_csr_if;
  logic        csr_req_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic        csr_rvalid_o;
  logic [31:0] csr_rdata_o;
  logic        csr_err_o;

  modport master (
    output csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
    input  csr_rvalid_o, csr_rdata_o, csr_err_o
  );

  modport slave (
    input  csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
    output csr_rvalid_o, csr_rdata_o, csr_err_o
  );
endinterface

// File: rtl/ibex_pmp_csr.sv
// pmpcfg/pmpaddr CSR storage with WARL, lock and granularity legalisation,
// feeding the packed per-region cfg/addr buses of the PMP checker.
module ibex_pmp_csr #(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  ibex_pmp_csr_if.slave                   csr,
  output logic                            pmp_update_o,
  output logic [6*PMPNumRegions-1:0]      csr_pmp_cfg_o,
  output logic [34*PMPNumRegions-1:0]     csr_pmp_addr_o
);

  localparam int unsigned MaxRegions = 16;
  localparam logic [1:0]  ModeOff    = 2'b00;
  localparam logic [1:0]  ModeTor    = 2'b01;
  localparam logic [1:0]  ModeNa4    = 2'b10;
  localparam logic [1:0]  ModeNapot  = 2'b11;

  // Read-back masks: NAPOT forces ones below bit G-1, OFF/TOR clear bits below G.
  localparam int unsigned NapotShift = (PMPGranularity >= 2) ? PMPGranularity - 1 : 0;
  localparam logic [31:0] NapotOnes  = 32'((33'd1 << NapotShift) - 33'd1);
  localparam logic [31:0] OffTorMask = ~32'((33'd1 << PMPGranularity) - 33'd1);

  typedef struct packed {
    logic       lock;
    logic [1:0] mode;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  pmp_cfg_t    cfg_q  [MaxRegions];
  pmp_cfg_t    cfg_d  [MaxRegions];
  logic [31:0] addr_q [MaxRegions];
  logic [31:0] addr_d [MaxRegions];

  logic        rvalid_q, err_q, update_q;
  logic [31:0] rdata_q;
  logic        err_d, update_d;
  logic [31:0] rdata_d;

  logic        is_cfg, is_addr;
  logic [3:0]  idx, idx_next;
  logic        next_tor_lock;
  logic        unused_wdata;

  assign is_cfg  = (csr.csr_addr_i[11:2] == 10'b0011_1010_00);
  assign is_addr = (csr.csr_addr_i[11:4] == 8'h3B);
  assign unused_wdata = ^{csr.csr_wdata_i[30:29], csr.csr_wdata_i[22:21],
                          csr.csr_wdata_i[14:13], csr.csr_wdata_i[6:5]};

  function automatic pmp_cfg_t cfg_legal(input logic [5:0] b, input pmp_cfg_t old);
    pmp_cfg_t c;
    c.lock = b[5];
    c.mode = b[4:3];
    c.x    = b[2];
    c.w    = b[1] & b[0];
    c.r    = b[0];
    if ((PMPGranularity >= 1) && (b[4:3] == ModeNa4)) c.mode = old.mode;
    return c;
  endfunction

  function automatic logic [31:0] addr_rd(input pmp_cfg_t c, input logic [31:0] a);
    logic [31:0] v;
    v = a;
    if (c.mode == ModeNapot)                          v = a | NapotOnes;
    else if ((c.mode == ModeOff) || (c.mode == ModeTor)) v = a & OffTorMask;
    return v;
  endfunction

  // Access decode, legalisation and next-state computation.
  always_comb begin
    cfg_d         = cfg_q;
    addr_d        = addr_q;
    rdata_d       = '0;
    err_d         = 1'b0;
    update_d      = 1'b0;
    idx           = '0;
    idx_next      = '0;
    next_tor_lock = 1'b0;
    if (csr.csr_req_i) begin
      if (is_cfg) begin
        for (int k = 0; k < 4; k++) begin
          idx = {csr.csr_addr_i[1:0], 2'(k)};
          if (32'(idx) < PMPNumRegions) begin
            if (!csr.csr_we_i) begin
              rdata_d[8*k +: 8] = {cfg_q[idx].lock, 2'b00, cfg_q[idx].mode,
                                   cfg_q[idx].x, cfg_q[idx].w, cfg_q[idx].r};
            end else if (!cfg_q[idx].lock) begin
              cfg_d[idx] = cfg_legal({csr.csr_wdata_i[8*k+7], csr.csr_wdata_i[8*k +: 5]},
                                     cfg_q[idx]);
            end
          end
        end
      end else if (is_addr) begin
        idx      = csr.csr_addr_i[3:0];
        idx_next = idx + 4'd1;
        // A locked TOR region above pins this register as its base address.
        next_tor_lock = (32'(idx) + 32'd1 < PMPNumRegions) && cfg_q[idx_next].lock &&
                        (cfg_q[idx_next].mode == ModeTor);
        if (32'(idx) < PMPNumRegions) begin
          if (!csr.csr_we_i) begin
            rdata_d = addr_rd(cfg_q[idx], addr_q[idx]);
          end else if (!cfg_q[idx].lock && !next_tor_lock) begin
            addr_d[idx] = csr.csr_wdata_i;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
    for (int r = 0; r < MaxRegions; r++) begin
      if ((cfg_d[r] != cfg_q[r]) || (addr_d[r] != addr_q[r])) update_d = 1'b1;
    end
  end

  // State and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < MaxRegions; r++) begin
        cfg_q[r]  <= '0;
        addr_q[r] <= '0;
      end
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      update_q <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      addr_q   <= addr_d;
      rvalid_q <= csr.csr_req_i;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      update_q <= update_d;
    end
  end

  assign csr.csr_rvalid_o = rvalid_q;
  assign csr.csr_rdata_o  = rdata_q;
  assign csr.csr_err_o    = err_q;
  assign pmp_update_o     = update_q;

  for (genvar r = 0; r < PMPNumRegions; r++) begin : g_region
    assign csr_pmp_cfg_o[6*r +: 6]   = cfg_q[r];
    assign csr_pmp_addr_o[34*r +: 34] = {addr_rd(cfg_q[r], addr_q[r]), 2'b00};
  end

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Directed bench for ibex_pmp_csr: G=0 and G=2 instances, response scoreboard plus bus checks.
module tb_ibex_pmp_csr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_pmp_csr_if ia ();
  ibex_pmp_csr_if ib ();

  logic          upd_a, upd_b;
  logic [23:0]   cfg_a, cfg_b;
  logic [135:0]  addr_a, addr_b;

  ibex_pmp_csr #(.PMPGranularity(0), .PMPNumRegions(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .csr(ia),
    .pmp_update_o(upd_a), .csr_pmp_cfg_o(cfg_a), .csr_pmp_addr_o(addr_a)
  );

  ibex_pmp_csr #(.PMPGranularity(2), .PMPNumRegions(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .csr(ib),
    .pmp_update_o(upd_b), .csr_pmp_cfg_o(cfg_b), .csr_pmp_addr_o(addr_b)
  );

  typedef struct {
    bit          dut;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ia.csr_rvalid_o === 1'b1 || ib.csr_rvalid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", {62'd0, ia.csr_rvalid_o, ib.csr_rvalid_o}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.dut == 1'b0) begin
          check("rvalid_a", {63'd0, ia.csr_rvalid_o}, 64'd1);
          check("rdata_a", {32'd0, ia.csr_rdata_o}, {32'd0, e.rdata});
          check("err_a", {63'd0, ia.csr_err_o}, {63'd0, e.err});
        end else begin
          check("rvalid_b", {63'd0, ib.csr_rvalid_o}, 64'd1);
          check("rdata_b", {32'd0, ib.csr_rdata_o}, {32'd0, e.rdata});
          check("err_b", {63'd0, ib.csr_err_o}, {63'd0, e.err});
        end
      end
    end
  end

  task automatic req(input bit b, input bit we, input logic [11:0] a, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee);
    exp_t e;
    if (!b) begin
      ia.csr_req_i = 1'b1; ia.csr_we_i = we; ia.csr_addr_i = a; ia.csr_wdata_i = wd;
      ib.csr_req_i = 1'b0;
    end else begin
      ib.csr_req_i = 1'b1; ib.csr_we_i = we; ib.csr_addr_i = a; ib.csr_wdata_i = wd;
      ia.csr_req_i = 1'b0;
    end
    e.dut = b; e.rdata = er; e.err = ee;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    ia.csr_req_i = 1'b0;
    ib.csr_req_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    ia.csr_req_i = 1'b0; ia.csr_we_i = 1'b0; ia.csr_addr_i = '0; ia.csr_wdata_i = '0;
    ib.csr_req_i = 1'b0; ib.csr_we_i = 1'b0; ib.csr_addr_i = '0; ib.csr_wdata_i = '0;
    repeat (3) @(negedge clk);
    // Request during reset is dropped.
    ia.csr_req_i = 1'b1; ia.csr_addr_i = 12'h3A0;
    @(negedge clk);
    rst = 1'b0;
    ia.csr_req_i = 1'b0;
    @(negedge clk);
    check("reset_rvalid", {63'd0, ia.csr_rvalid_o}, 64'd0);
    check("reset_upd", {63'd0, upd_a}, 64'd0);
    check("reset_cfg_a", {40'd0, cfg_a}, 64'd0);
    check("reset_addr_a_lo", addr_a[63:0], 64'd0);
    check("reset_addr_a_hi", {56'd0, addr_a[135:128]} | addr_a[127:64], 64'd0);

    // G=0: basic reads, back-to-back.
    req(0, 0, 12'h3A0, 0, 0, 0);
    req(0, 0, 12'h3B0, 0, 0, 0);
    req(0, 1, 12'h3A0, 32'h0000_0F0A, 0, 0);
    check("wr_cfg_upd", {63'd0, upd_a}, 64'd1);
    check("wr_cfg_bus", {40'd0, cfg_a}, 64'h3C8);
    req(0, 0, 12'h3A0, 0, 32'h0000_0F08, 0);
    check("rd_cfg_noupd", {63'd0, upd_a}, 64'd0);

    // Locked TOR region1 protects pmpaddr0 and pmpaddr1.
    req(0, 1, 12'h3B1, 32'h2000_0000, 0, 0);
    check("wr_addr1_upd", {63'd0, upd_a}, 64'd1);
    check("addr1_bus", {30'd0, addr_a[67:34]}, 64'h8000_0000);
    req(0, 1, 12'h3A0, 32'h0000_8808, 0, 0);
    check("lock1_upd", {63'd0, upd_a}, 64'd1);
    check("lock1_cfg", {40'd0, cfg_a}, 64'hA08);
    req(0, 1, 12'h3B0, 32'h0000_1234, 0, 0);
    check("tor_base_ignored", {63'd0, upd_a}, 64'd0);
    req(0, 1, 12'h3B1, 32'h0, 0, 0);
    check("locked_addr_ignored", {63'd0, upd_a}, 64'd0);
    req(0, 0, 12'h3B1, 0, 32'h2000_0000, 0);
    req(0, 0, 12'h3B0, 0, 0, 0);
    req(0, 0, 12'h3A0, 0, 32'h0000_8808, 0);

    // Unimplemented regions and illegal addresses.
    req(0, 1, 12'h3BF, 32'hFFFF_FFFF, 0, 0);
    check("unimpl_addr_noupd", {63'd0, upd_a}, 64'd0);
    req(0, 0, 12'h3BF, 0, 0, 0);
    req(0, 1, 12'h3A1, 32'hFFFF_FFFF, 0, 0);
    check("unimpl_cfg_noupd", {63'd0, upd_a}, 64'd0);
    req(0, 0, 12'h3A1, 0, 0, 0);
    req(0, 0, 12'h7C0, 0, 0, 1);
    req(0, 1, 12'h3A4, 32'hFFFF_FFFF, 0, 1);
    check("illegal_noupd", {63'd0, upd_a}, 64'd0);
    check("illegal_cfg_kept", {40'd0, cfg_a}, 64'hA08);
    req(0, 1, 12'h3B3, 32'h0000_ABCD, 0, 0);
    check("last_addr_upd", {63'd0, upd_a}, 64'd1);
    req(0, 0, 12'h3B3, 0, 32'h0000_ABCD, 0);
    idle();
    check("upd_single_pulse", {63'd0, upd_a}, 64'd0);

    // Reset clears locks; byte-wise lock on region0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_cfg_clear", {40'd0, cfg_a}, 64'd0);
    req(0, 1, 12'h3A0, 32'h0010_0180, 0, 0);
    check("lock0_upd", {63'd0, upd_a}, 64'd1);
    check("lock0_cfg", {40'd0, cfg_a}, 64'h10060);
    req(0, 1, 12'h3A0, 32'h0000_0007, 0, 0);
    check("lock0_other_bytes_upd", {63'd0, upd_a}, 64'd1);
    check("lock0_byte_kept", {40'd0, cfg_a}, 64'h20);
    req(0, 0, 12'h3A0, 0, 32'h0000_0080, 0);
    req(0, 1, 12'h3B0, 32'h5, 0, 0);
    check("lock0_addr_ignored", {63'd0, upd_a}, 64'd0);
    req(0, 0, 12'h3B0, 0, 0, 0);

    // Reset arriving while a write response is pending.
    req(0, 1, 12'h3B2, 32'h55, 0, 0);
    check("pending_wr_visible", {30'd0, addr_a[101:68]}, 64'h154);
    rst = 1'b1;
    ia.csr_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_pending_rvalid", {63'd0, ia.csr_rvalid_o}, 64'd0);
    check("rst_pending_cfg", {40'd0, cfg_a}, 64'd0);
    check("rst_pending_addr", {30'd0, addr_a[101:68]}, 64'd0);

    // G=2 granularity read-back and NA4 rejection.
    req(1, 1, 12'h3A0, 32'h18, 0, 0);
    check("g2_napot_upd", {63'd0, upd_b}, 64'd1);
    req(1, 1, 12'h3B0, 32'h0, 0, 0);
    check("g2_same_addr_noupd", {63'd0, upd_b}, 64'd0);
    req(1, 0, 12'h3B0, 0, 32'h1, 0);
    check("g2_napot_bus", {30'd0, addr_b[33:0]}, 64'h4);
    req(1, 1, 12'h3B0, 32'hF2, 0, 0);
    req(1, 0, 12'h3B0, 0, 32'hF3, 0);
    req(1, 1, 12'h3A0, 32'h08, 0, 0);
    req(1, 0, 12'h3B0, 0, 32'hF0, 0);
    check("g2_tor_bus", {30'd0, addr_b[33:0]}, 64'h3C0);
    req(1, 1, 12'h3A0, 32'h10, 0, 0);
    check("g2_na4_from_tor_noupd", {63'd0, upd_b}, 64'd0);
    req(1, 0, 12'h3A0, 0, 32'h08, 0);
    req(1, 1, 12'h3A0, 32'h18, 0, 0);
    req(1, 1, 12'h3A0, 32'h11, 0, 0);
    check("g2_na4_other_fields_upd", {63'd0, upd_b}, 64'd1);
    req(1, 0, 12'h3A0, 0, 32'h19, 0);
    check("g2_cfg_bus", {58'd0, cfg_b[5:0]}, 64'h19);
    idle();
    idle();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
